// File: rtl/icache_refill_controller.sv
// Instruction-cache line refill sequencer: picks a victim way, issues one burst read and streams beats into the data RAM.
// Define ICACHE_PLRU_EN for tree pseudo-LRU replacement; otherwise a per-index round-robin pointer is used.
module icache_refill_controller #(
    parameter int number_of_sets         = 4,
    parameter int log_of_number_of_sets  = 2,
    parameter int number_of_lines        = 64,
    parameter int log_of_number_of_lines = 6,
    parameter int words_per_line         = 8,
    parameter int log_of_words_per_line  = 3,
    parameter int data_width             = 32,
    parameter int addr_width             = 30
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              miss_valid,
    output logic                              miss_ready,
    input  logic [addr_width-1:0]             miss_addr,
    input  logic                              hit_valid,
    input  logic [log_of_number_of_lines-1:0] hit_index,
    input  logic [log_of_number_of_sets-1:0]  hit_way,
    input  logic                              flush,
    input  logic [log_of_number_of_lines-1:0] valid_rd_index,
    output logic [number_of_sets-1:0]         valid_rd,
    output logic                              mem_read,
    output logic [addr_width-1:0]             mem_address,
    output logic [log_of_words_per_line:0]    mem_burstcount,
    input  logic                              mem_waitrequest,
    input  logic [data_width-1:0]             mem_readdata,
    input  logic                              mem_readdatavalid,
    output logic                              ram_we,
    output logic [log_of_number_of_lines-1:0] ram_index,
    output logic [log_of_number_of_sets-1:0]  ram_way,
    output logic [log_of_words_per_line-1:0]  ram_word,
    output logic [data_width-1:0]             ram_wdata,
    output logic                              refill_done
);

    localparam int WAY_W = log_of_number_of_sets;
    localparam int IDX_W = log_of_number_of_lines;
    localparam int OFF_W = log_of_words_per_line;

    typedef enum logic [1:0] {IDLE, REQ, RECV, DONE} state_t;

    state_t state, state_next;

    logic [number_of_sets-1:0] valid [number_of_lines];
    logic [IDX_W-1:0]          index_q;
    logic [addr_width-1:0]     line_addr;
    logic [WAY_W-1:0]          victim_q;
    logic [OFF_W-1:0]          beat;
    logic                      flush_pending;

    logic [IDX_W-1:0]          miss_index;
    logic [number_of_sets-1:0] miss_row;
    logic [WAY_W-1:0]          repl_way;
    logic [WAY_W-1:0]          victim_sel;
    logic                      last_beat;
    logic                      clear_all;
    logic                      unused_offset;

    function automatic logic [WAY_W-1:0] first_invalid(input logic [number_of_sets-1:0] row);
        logic [WAY_W-1:0] f;
        f = '0;
        for (int w = number_of_sets - 1; w >= 0; w--) begin
            if (!row[w]) f = WAY_W'(w);
        end
        return f;
    endfunction

    assign miss_index    = miss_addr[OFF_W +: IDX_W];
    assign miss_row      = valid[miss_index];
    assign victim_sel    = (~&miss_row) ? first_invalid(miss_row) : repl_way;
    assign last_beat     = mem_readdatavalid && (beat == OFF_W'(words_per_line - 1));
    // A flush seen while busy is deferred so the in-flight line is wiped along with the rest.
    assign clear_all     = (state == IDLE && flush) || (state == DONE && (flush_pending || flush));
    assign unused_offset = ^miss_addr[OFF_W-1:0];

    assign miss_ready     = (state == IDLE);
    assign mem_read       = (state == REQ);
    assign mem_address    = line_addr;
    assign mem_burstcount = (OFF_W + 1)'(words_per_line);
    assign ram_we         = (state == RECV) && mem_readdatavalid;
    assign ram_index      = index_q;
    assign ram_way        = victim_q;
    assign ram_word       = beat;
    assign ram_wdata      = mem_readdata;
    assign refill_done    = (state == DONE);
    assign valid_rd       = valid[valid_rd_index];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (miss_valid)       state_next = REQ;
            REQ:     if (!mem_waitrequest) state_next = RECV;
            RECV:    if (last_beat)        state_next = DONE;
            DONE:                          state_next = IDLE;
            default:                       state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            beat          <= '0;
            flush_pending <= 1'b0;
            for (int i = 0; i < number_of_lines; i++) valid[i] <= '0;
        end else begin
            if (state == IDLE)                          beat <= '0;
            else if (state == RECV && mem_readdatavalid) beat <= beat + OFF_W'(1);

            if (state == DONE)                   flush_pending <= 1'b0;
            else if (flush && state != IDLE)     flush_pending <= 1'b1;

            if (clear_all) begin
                for (int i = 0; i < number_of_lines; i++) valid[i] <= '0;
            end else if (state == DONE) begin
                valid[index_q][victim_q] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && miss_valid) begin
            index_q   <= miss_index;
            line_addr <= {miss_addr[addr_width-1:OFF_W], OFF_W'(0)};
            victim_q  <= victim_sel;
        end
    end

`ifdef ICACHE_PLRU_EN
    // Heap-ordered tree; a 0 node sends the victim walk to the lower half.
    logic [number_of_sets-2:0] plru [number_of_lines];

    function automatic logic [WAY_W-1:0] plru_walk(input logic [number_of_sets-2:0] t);
        logic [WAY_W-1:0] w;
        int node;
        w    = '0;
        node = 0;
        for (int l = WAY_W - 1; l >= 0; l--) begin
            w[l] = t[node];
            node = 2 * node + 1 + (t[node] ? 1 : 0);
        end
        return w;
    endfunction

    function automatic logic [number_of_sets-2:0] plru_touch(input logic [number_of_sets-2:0] t,
                                                             input logic [WAY_W-1:0] w);
        logic [number_of_sets-2:0] r;
        int node;
        r    = t;
        node = 0;
        for (int l = WAY_W - 1; l >= 0; l--) begin
            r[node] = ~w[l];
            node    = 2 * node + 1 + (w[l] ? 1 : 0);
        end
        return r;
    endfunction

    assign repl_way = plru_walk(plru[miss_index]);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < number_of_lines; i++) plru[i] <= '0;
        end else begin
            if (hit_valid && !(state == DONE && hit_index == index_q))
                plru[hit_index] <= plru_touch(plru[hit_index], hit_way);
            if (state == DONE)
                plru[index_q] <= plru_touch(plru[index_q], victim_q);
        end
    end
`else
    logic [WAY_W-1:0] rr_ptr [number_of_lines];
    logic             unused_hit;

    assign repl_way   = rr_ptr[miss_index];
    assign unused_hit = ^{hit_valid, hit_index, hit_way};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < number_of_lines; i++) rr_ptr[i] <= '0;
        end else if (state == DONE) begin
            rr_ptr[index_q] <= rr_ptr[index_q] + WAY_W'(1);
        end
    end
`endif

endmodule
